disp_scan_ctrl: RTL and testbench



---
 rtl/disp_scan_ctrl.sv | 139 +++++++++++++
 tb/tb_disp_scan_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/disp_scan_ctrl.sv
// Display front-end: sequential double-dabble binary-to-BCD converter plus
// four-digit time-multiplexed scan producing anode enables and decoder codes.
module disp_scan_ctrl #(
  parameter int REFRESH_DIV = 100000,
  parameter bit LZ_BLANK    = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [13:0] value,
  input  logic [1:0]  mode,
  output logic        busy,
  output logic [3:0]  an,
  output logic [3:0]  digit
);

  localparam int unsigned PW      = $clog2(REFRESH_DIV);
  localparam logic [PW-1:0] PS_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [13:0] VAL_MAX = 14'd9999;

  localparam logic S_IDLE = 1'b0;
  localparam logic S_CONV = 1'b1;

  localparam logic [3:0] CODE_A     = 4'd10;
  localparam logic [3:0] CODE_L     = 4'd11;
  localparam logic [3:0] CODE_I     = 4'd12;
  localparam logic [3:0] CODE_F     = 4'd13;
  localparam logic [3:0] CODE_DASH  = 4'd14;
  localparam logic [3:0] CODE_BLANK = 4'd15;

  logic          state_q, state_d;
  logic [13:0]   bin_q, bin_d;
  logic [15:0]   bcd_q, bcd_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [15:0]   disp_q, disp_d;
  logic [PW-1:0] ps_q, ps_d;
  logic [1:0]    idx_q, idx_d;

  logic [15:0]   adj;
  logic [15:0]   bcd_shift;
  logic [3:0]    nib;
  logic [3:0]    lz;
  logic          blank;

  // Converter: add-3 correction on every nibble >= 5, then shift {bcd, bin}.
  always_comb begin
    adj = bcd_q;
    for (int unsigned i = 0; i < 4; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
    bcd_shift = {adj[14:0], bin_q[13]};

    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    disp_d  = disp_q;

    case (state_q)
      S_IDLE: begin
        if (load) begin
          bin_d   = (value > VAL_MAX) ? VAL_MAX : value;
          bcd_d   = '0;
          cnt_d   = '0;
          state_d = S_CONV;
        end
      end
      default: begin
        bcd_d = bcd_shift;
        bin_d = {bin_q[12:0], 1'b0};
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd13) begin
          disp_d  = bcd_shift;
          state_d = S_IDLE;
        end
      end
    endcase
  end

  always_comb begin
    ps_d  = ps_q + PW'(1);
    idx_d = idx_q;
    if (ps_q == PS_LAST) begin
      ps_d  = '0;
      idx_d = idx_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      disp_q  <= '0;
      ps_q    <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      disp_q  <= disp_d;
      ps_q    <= ps_d;
      idx_q   <= idx_d;
    end
  end

  assign busy = (state_q == S_CONV);

  // lz[i]: nibble i and everything above it are zero; digit 0 is never blanked.
  always_comb begin
    nib   = disp_q[{idx_q, 2'b00} +: 4];
    lz[3] = (disp_q[15:12] == 4'd0);
    lz[2] = lz[3] && (disp_q[11:8] == 4'd0);
    lz[1] = lz[2] && (disp_q[7:4] == 4'd0);
    lz[0] = 1'b0;
    blank = LZ_BLANK && lz[idx_q];

    an    = (mode == 2'd3) ? 4'b1111 : ~(4'b0001 << idx_q);
    digit = CODE_BLANK;
    case (mode)
      2'd0: digit = blank ? CODE_BLANK : nib;
      2'd1: begin
        case (idx_q)
          2'd0:    digit = CODE_L;
          2'd1:    digit = CODE_I;
          2'd2:    digit = CODE_A;
          default: digit = CODE_F;
        endcase
      end
      2'd2:    digit = CODE_DASH;
      default: digit = CODE_BLANK;
    endcase
  end

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Self-checking bench for disp_scan_ctrl: directed scenarios plus random
// stimulus, compared every cycle against an integer-arithmetic display model.
module tb_disp_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load;
  logic [13:0] value;
  logic [1:0]  mode;
  logic        busy;
  logic [3:0]  an;
  logic [3:0]  digit;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: edges since reset, remaining busy cycles, shown/pending numbers.
  int cyc      = 0;
  int busy_cnt = 0;
  int shown    = 0;
  int pending  = 0;

  disp_scan_ctrl #(.REFRESH_DIV(4), .LZ_BLANK(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .value (value),
    .mode  (mode),
    .busy  (busy),
    .an    (an),
    .digit (digit)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int pow10(input int i);
    int p = 1;
    for (int k = 0; k < i; k++) p = p * 10;
    return p;
  endfunction

  function automatic int exp_digit(input int v, input int m, input int i);
    case (m)
      0: begin
        if (i > 0 && v < pow10(i)) return 15;
        return (v / pow10(i)) % 10;
      end
      1: begin
        case (i)
          0: return 11;
          1: return 12;
          2: return 10;
          default: return 13;
        endcase
      end
      2: return 14;
      default: return 15;
    endcase
  endfunction

  function automatic int exp_an(input int m, input int i);
    if (m == 3) return 15;
    return 15 ^ (1 << i);
  endfunction

  // One clock: drive inputs, advance model at the edge, compare 1 time unit later.
  task automatic step(input logic l, input int v, input int m, input logic r);
    int idx;
    rst_n = r;
    load  = l;
    value = 14'(v);
    mode  = 2'(m);
    @(posedge clk);
    if (!r) begin
      cyc = 0; busy_cnt = 0; shown = 0;
    end else begin
      cyc++;
      if (busy_cnt > 0) begin
        busy_cnt--;
        if (busy_cnt == 0) shown = pending;
      end else if (l) begin
        pending  = (v > 9999) ? 9999 : v;
        busy_cnt = 14;
      end
    end
    #1;
    idx = (cyc / 4) % 4;
    chk("busy", int'(busy), (busy_cnt > 0) ? 1 : 0);
    chk("an", int'(an), exp_an(m, idx));
    chk("digit", int'(digit), exp_digit(shown, m, idx));
  endtask

  task automatic idle(input int n, input int m);
    for (int k = 0; k < n; k++) step(1'b0, 0, m, 1'b1);
  endtask

  task automatic convert(input int v, output int len);
    step(1'b1, v, 0, 1'b1);
    len = 0;
    while (busy && len < 40) begin
      len++;
      step(1'b0, 0, 0, 1'b1);
    end
  endtask

  int len;
  int m_r;

  initial begin
    rst_n = 1'b0; load = 1'b0; value = '0; mode = 2'd0;

    // Reset and initial scan of a zero value.
    for (int k = 0; k < 3; k++) step(1'b0, 0, 0, 1'b0);
    chk("rst_an", int'(an), 14);
    chk("rst_digit", int'(digit), 0);
    chk("rst_busy", int'(busy), 0);
    idle(17, 0);

    // Conversion latency and display values.
    convert(1234, len);
    chk("busy_len_1234", len, 14);
    idle(16, 0);
    convert(42, len);
    idle(16, 0);
    convert(1005, len);
    idle(16, 0);
    convert(12000, len);
    chk("busy_len_sat", len, 14);
    idle(16, 0);

    // Message modes and a mid-slot return to number mode.
    idle(16, 1);
    idle(16, 2);
    idle(16, 3);
    idle(2, 1);
    idle(6, 0);

    // Load during a conversion is ignored.
    step(1'b1, 1234, 0, 1'b1);
    idle(5, 0);
    step(1'b1, 777, 0, 1'b1);
    len = 6;
    while (busy && len < 40) begin
      len++;
      step(1'b0, 0, 0, 1'b1);
    end
    chk("busy_len_ignored", len, 14);
    idle(16, 0);
    convert(777, len);
    idle(16, 0);

    // Reset mid-conversion aborts it, then a fresh conversion.
    step(1'b1, 4321, 0, 1'b1);
    idle(6, 0);
    step(1'b1, 999, 0, 1'b0);
    chk("abort_busy", int'(busy), 0);
    idle(8, 0);
    convert(58, len);
    chk("busy_len_58", len, 14);
    idle(16, 0);

    // Random traffic, occasional reset, mode changes and out-of-range values.
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 15) == 0) m_r = $urandom_range(0, 3);
      else if (k % 50 == 0) m_r = 0;
      step(($urandom_range(0, 9) == 0), int'($urandom_range(0, 16383)),
           m_r, ($urandom_range(0, 299) != 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
